// File: rtl/lemmings_pkg.sv
// Shared definitions for the Lemmings world model, the walker and their benches.
package lemmings_pkg;

   typedef enum logic {
      SURF = 1'b0,
      FALL = 1'b1
   } world_state_e;

   localparam int SPLAT_THRESH = 21;
   localparam int FALL_LEN_W   = 8;
   localparam logic [FALL_LEN_W-1:0] FALL_LEN_MAX = '1;

   // Increment that sticks at the top of the fall-length range.
   function automatic logic [FALL_LEN_W-1:0] sat_inc(input logic [FALL_LEN_W-1:0] v);
      return (v == FALL_LEN_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/lemmings_fall_counter.sv
// Counts ground-low cycles of a fall, captures the length on landing and
// latches a sticky splat flag when a completed fall was too long to survive.
module lemmings_fall_counter
   import lemmings_pkg::*;
(
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  count,
   input  logic                  capture,
   output logic [FALL_LEN_W-1:0] fall_len,
   output logic                  splat
);

   logic [FALL_LEN_W-1:0] run;
   logic [FALL_LEN_W-1:0] run_next;

   assign run_next = sat_inc(run);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         run      <= '0;
         fall_len <= '0;
         splat    <= 1'b0;
      end else if (count) begin
         // The landing cycle is itself a ground-low cycle, so it is included.
         if (capture) begin
            run      <= '0;
            fall_len <= run_next;
            if (run_next >= FALL_LEN_W'(SPLAT_THRESH))
               splat <= 1'b1;
         end else begin
            run <= run_next;
         end
      end
   end

endmodule

// File: rtl/lemmings_world.sv
// 1-D terrain environment closing the loop around a Lemmings4 walker:
// tracks position, holes, digging and falls, and reports ground/bump as Moore outputs.
module lemmings_world
   import lemmings_pkg::*;
#(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] GROUND_MAP = '1,
   parameter int               START_POS  = 4,
   parameter int               HOLE_DEPTH = 5,
   parameter int               DIG_CYCLES = 3,
   parameter int               DIG_DEPTH  = 25
) (
   input  logic                      clk,
   input  logic                      areset,
   input  logic                      walk_left,
   input  logic                      walk_right,
   input  logic                      aaah,
   input  logic                      digging,
   output logic                      ground,
   output logic                      bump_left,
   output logic                      bump_right,
   output logic [$clog2(WIDTH)-1:0]  pos,
   output logic [FALL_LEN_W-1:0]     fall_len,
   output logic                      splat
);

   localparam int POS_W = $clog2(WIDTH);
   localparam int REM_W = $clog2(((HOLE_DEPTH > DIG_DEPTH) ? HOLE_DEPTH : DIG_DEPTH) + 1);
   localparam int DIG_W = $clog2(DIG_CYCLES + 1);

   localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
   localparam logic [POS_W-1:0] POS_MAX   = POS_W'(WIDTH - 1);
   localparam logic [REM_W-1:0] HOLE_REM  = REM_W'(HOLE_DEPTH);
   localparam logic [REM_W-1:0] DIG_REM   = REM_W'(DIG_DEPTH);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIG_CYCLES - 1);

   world_state_e     state;
   logic [WIDTH-1:0] terrain;
   logic [DIG_W-1:0] dig_cnt;
   logic [REM_W-1:0] rem;
   logic [POS_W-1:0] pos_l;
   logic [POS_W-1:0] pos_r;
   logic             landing;

   // The walker's scream is observed by the bench, never by this model.
   logic unused_aaah;
   assign unused_aaah = aaah;

   assign pos_l   = pos - 1'b1;
   assign pos_r   = pos + 1'b1;
   assign landing = (state == FALL) && (rem == REM_W'(1));

   assign ground     = (state != FALL);
   assign bump_left  = (state == SURF) && (pos == '0);
   assign bump_right = (state == SURF) && (pos == POS_MAX);

   // NOTE: every register here is updated with <= so all of them see the
   // pre-edge values of each other, exactly like the hardware flops.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         // NOTE: terrain is a flop vector, not a RAM, so it can and must be
         // reset: a reset mid-game restores the original map.
         state   <= SURF;
         pos     <= POS_START;
         terrain <= GROUND_MAP;
         dig_cnt <= '0;
         rem     <= '0;
      end else begin
         case (state)
            SURF: begin
               if (digging) begin
                  if (dig_cnt == DIG_LAST) begin
                     terrain[pos] <= 1'b0;
                     state        <= FALL;
                     rem          <= DIG_REM;
                     dig_cnt      <= '0;
                  end else begin
                     dig_cnt <= dig_cnt + 1'b1;
                  end
               end else begin
                  dig_cnt <= '0;
                  // walk_left wins even when blocked by the wall.
                  if (walk_left) begin
                     if (pos != '0) begin
                        pos <= pos_l;
                        if (!terrain[pos_l]) begin
                           state <= FALL;
                           rem   <= HOLE_REM;
                        end
                     end
                  end else if (walk_right) begin
                     if (pos != POS_MAX) begin
                        pos <= pos_r;
                        if (!terrain[pos_r]) begin
                           state <= FALL;
                           rem   <= HOLE_REM;
                        end
                     end
                  end
               end
            end
            FALL: begin
               dig_cnt <= '0;
               rem     <= rem - 1'b1;
               if (landing) begin
                  state        <= SURF;
                  terrain[pos] <= 1'b1;
               end
            end
            default: state <= SURF;
         endcase
      end
   end

   lemmings_fall_counter u_fall_counter (
      .clk      (clk),
      .areset   (areset),
      .count    (state == FALL),
      .capture  (landing),
      .fall_len (fall_len),
      .splat    (splat)
   );

endmodule

// File: tb/tb_lemmings_world.sv
// Directed bench for lemmings_world: walking, holes, digging, reset mid-fall,
// and a closed loop with a small Lemmings4 walker model on both sides of the splat limit.
module tb_lemmings_world;
   import lemmings_pkg::*;

   typedef enum logic [2:0] {W_WL, W_WR, W_FL, W_FR, W_DEAD} walker_e;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Open-loop instance: hole at column 5.
   logic       areset, walk_left, walk_right, aaah, digging;
   logic       ground, bump_left, bump_right, splat;
   logic [3:0] pos;
   logic [7:0] fall_len;

   lemmings_world #(.GROUND_MAP(16'hFFDF)) u_dut (
      .clk(clk), .areset(areset), .walk_left(walk_left), .walk_right(walk_right),
      .aaah(aaah), .digging(digging), .ground(ground), .bump_left(bump_left),
      .bump_right(bump_right), .pos(pos), .fall_len(fall_len), .splat(splat)
   );

   // Closed-loop instances: hole at column 2, fall of 21 vs 20 cycles.
   logic       areset_cl;
   walker_e    ws21, ws20;
   int         wc21, wc20;
   logic       g21, bl21, br21, sp21, g20, bl20, br20, sp20;
   logic [3:0] pos21, pos20;
   logic [7:0] fl21, fl20;

   lemmings_world #(.GROUND_MAP(16'hFFFB), .HOLE_DEPTH(21)) u_w21 (
      .clk(clk), .areset(areset_cl), .walk_left(ws21 == W_WL), .walk_right(ws21 == W_WR),
      .aaah(ws21 == W_FL || ws21 == W_FR), .digging(1'b0), .ground(g21), .bump_left(bl21),
      .bump_right(br21), .pos(pos21), .fall_len(fl21), .splat(sp21)
   );

   lemmings_world #(.GROUND_MAP(16'hFFFB), .HOLE_DEPTH(20)) u_w20 (
      .clk(clk), .areset(areset_cl), .walk_left(ws20 == W_WL), .walk_right(ws20 == W_WR),
      .aaah(ws20 == W_FL || ws20 == W_FR), .digging(1'b0), .ground(g20), .bump_left(bl20),
      .bump_right(br20), .pos(pos20), .fall_len(fl20), .splat(sp20)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic r, input logic d);
      walk_left  = l;
      walk_right = r;
      digging    = d;
   endtask

   // Lemmings4 walker: dies if it was falling for more than 20 cycles.
   task automatic walker_step(input walker_e s, input int c, input logic g,
                              input logic bl, input logic br,
                              output walker_e ns, output int nc);
      ns = s;
      nc = c;
      case (s)
         W_WL: if (!g) begin ns = W_FL; nc = 0; end else if (bl) ns = W_WR;
         W_WR: if (!g) begin ns = W_FR; nc = 0; end else if (br) ns = W_WL;
         W_FL: if (g) ns = (c >= 20) ? W_DEAD : W_WL; else nc = c + 1;
         W_FR: if (g) ns = (c >= 20) ? W_DEAD : W_WR; else nc = c + 1;
         default: ns = W_DEAD;
      endcase
   endtask

   initial begin
      walker_e n21, n20;
      int      c21, c20, low_cnt;

      areset = 1'b1; areset_cl = 1'b1; aaah = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      ws21 = W_WL; ws20 = W_WL; wc21 = 0; wc20 = 0;
      repeat (2) tick();

      check("reset ground", ground, 1);
      check("reset pos", pos, 4);
      check("reset bump_left", bump_left, 0);
      check("reset bump_right", bump_right, 0);
      check("reset fall_len", fall_len, 0);
      check("reset splat", splat, 0);
      areset = 1'b0;

      // Walk left into the wall.
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t1 pos", pos, 4 - i);
         check("t1 bump_left", bump_left, (i == 4));
      end
      tick();
      check("t1 wall pos", pos, 0);
      check("t1 ground", ground, 1);

      // Walk right into the hole at column 5; inputs held during the fall.
      drive(1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      check("t2 pos before hole", pos, 4);
      check("t2 bump_left off", bump_left, 0);
      tick();
      check("t2 pos on hole", pos, 5);
      check("t2 ground low", ground, 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t2 ground still low", ground, 0);
         check("t2 pos frozen", pos, 5);
      end
      tick();
      check("t2 landed ground", ground, 1);
      check("t2 fall_len", fall_len, 5);
      check("t2 splat", splat, 0);
      drive(1'b1, 1'b0, 1'b0); tick();
      check("t2 back pos", pos, 4);
      drive(1'b0, 1'b1, 1'b0); tick();
      check("t2 recross pos", pos, 5);
      check("t2 recross ground", ground, 1);
      drive(1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0); tick();
      check("t2 idle hold pos", pos, 4);

      // Dig through at column 4.
      drive(1'b0, 1'b0, 1'b1);
      tick(); check("t3 dig1 ground", ground, 1);
      tick(); check("t3 dig2 ground", ground, 1);
      tick(); check("t3 dig3 ground", ground, 0);
      drive(1'b0, 1'b0, 1'b0);
      low_cnt = 1;
      for (int i = 0; i < 40 && ground == 1'b0; i++) begin
         tick();
         if (!ground) low_cnt++;
      end
      check("t3 low cycles", low_cnt, 25);
      check("t3 fall_len", fall_len, 25);
      check("t3 splat", splat, 1);
      check("t3 pos", pos, 4);

      // Interrupted digging never breaks the column.
      drive(1'b0, 1'b0, 1'b1); tick(); check("t4 a1 ground", ground, 1);
      tick(); check("t4 a2 ground", ground, 1);
      drive(1'b0, 1'b0, 1'b0); tick(); check("t4 gap ground", ground, 1);
      drive(1'b0, 1'b0, 1'b1); tick(); check("t4 b1 ground", ground, 1);
      tick(); check("t4 b2 ground", ground, 1);
      drive(1'b0, 1'b0, 1'b0); tick();
      check("t4 ground", ground, 1);
      check("t4 splat sticky", splat, 1);
      check("t4 fall_len kept", fall_len, 25);

      // Reset during the 3rd cycle of a dig fall at column 6.
      drive(1'b0, 1'b1, 1'b0); tick();
      check("t5 filled col5 ground", ground, 1);
      tick();
      check("t5 pos", pos, 6);
      drive(1'b0, 1'b0, 1'b1); repeat (3) tick();
      check("t5 falling", ground, 0);
      drive(1'b0, 1'b0, 1'b0); repeat (2) tick();
      #2 areset = 1'b1;
      #1;
      check("t5 reset ground", ground, 1);
      check("t5 reset pos", pos, 4);
      check("t5 reset fall_len", fall_len, 0);
      check("t5 reset splat", splat, 0);
      @(negedge clk) areset = 1'b0;
      tick();
      check("t5 idle ground", ground, 1);
      drive(1'b0, 1'b1, 1'b0); tick();
      check("t5 hole reloaded", ground, 0);
      drive(1'b0, 1'b0, 1'b0); repeat (5) tick();
      check("t5 landed", ground, 1);
      check("t5 fall_len", fall_len, 5);

      // Right wall.
      drive(1'b0, 1'b1, 1'b0); repeat (10) tick();
      check("right wall pos", pos, 15);
      check("right bump", bump_right, 1);
      tick();
      check("right wall hold", pos, 15);
      drive(1'b0, 1'b0, 1'b0);

      // Closed loop with the walker model.
      areset_cl = 1'b0;
      for (int i = 0; i < 80; i++) begin
         walker_step(ws21, wc21, g21, bl21, br21, n21, c21);
         walker_step(ws20, wc20, g20, bl20, br20, n20, c20);
         tick();
         ws21 = n21; wc21 = c21;
         ws20 = n20; wc20 = c20;
      end
      check("t6 w21 dead", ws21 == W_DEAD, 1);
      check("t6 w21 fall_len", fl21, 21);
      check("t6 w21 splat", sp21, 1);
      check("t6 w21 pos held", pos21, 2);
      check("t6 w20 alive", ws20 == W_DEAD, 0);
      check("t6 w20 fall_len", fl20, 20);
      check("t6 w20 splat", sp20, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
